// File: rtl/rx_link_pkg.sv
// -----------------------------------------------------------------------------
// rx_link_pkg
// Shared definitions for the battleship serial link receive path.
//   - link_state_e    : sequencer states of rx_link_controller
//   - LINK_DATA_WIDTH : packet width produced by the Receiver (Dout)
//   - LINK_BIT_TIME   : clock cycles per serial bit at 27 MHz
//   - TIMER_WIDTH     : width of the reset/backoff down-counter
// -----------------------------------------------------------------------------
package rx_link_pkg;

  localparam int unsigned LINK_DATA_WIDTH = 30;
  localparam int unsigned LINK_BIT_TIME   = 27;
  localparam int unsigned TIMER_WIDTH     = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RESET_RX = 3'd1,
    LISTEN   = 3'd2,
    BACKOFF  = 3'd3,
    HOLD     = 3'd4,
    ERROR    = 3'd5
  } link_state_e;

  // A request is in flight in every state except IDLE and ERROR.
  function automatic logic state_is_busy(input link_state_e s);
    return (s != IDLE) && (s != ERROR);
  endfunction

endpackage

// File: rtl/rx_link_timer.sv
// -----------------------------------------------------------------------------
// rx_link_timer
// Loadable down-counter with a done flag. Loading value N-1 on state entry
// makes done_o rise after the state has been occupied for exactly N cycles.
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (count cleared)
//   load_i     : load load_val_i this cycle
//   load_val_i : reload value
//   done_o     : count has reached zero
// -----------------------------------------------------------------------------
module rx_link_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: reload wins, otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != ZERO_C) begin
      count_d = count_q - ONE_C;
    end else begin
      count_d = ZERO_C;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= ZERO_C;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == ZERO_C);

endmodule

// File: rtl/rx_link_controller.sv
// -----------------------------------------------------------------------------
// rx_link_controller
// Sequencer for the serial Receiver. Holds the Receiver in reset while idle,
// arms it on Start, captures a completed packet and offers it to game logic
// over Pkt_valid/Pkt_ack. Receiver timeouts are retried after a backoff; the
// attempt after MAX_RETRIES retries is the last, after which Link_error is
// raised and held until Reset.
//
// Optional feature macro: RX_PARITY_CHECK_EN
//   When defined, the MSB of each received packet is checked as even parity
//   over the remaining bits; a mismatch is handled like a Receiver timeout and
//   pulses Parity_err for one cycle.
//
// Ports:
//   Clock, Reset           : clock, synchronous active-high reset
//   Start                  : request one packet (IDLE only)
//   Abort                  : cancel attempt (RESET_RX, LISTEN, BACKOFF)
//   Rec_Reset, Rec_en      : Receiver reset / enable
//   Rec_Dout, Rec_Timeout,
//   Rec_OutValid           : Receiver data, timeout strobe, packet strobe
//   Pkt_data, Pkt_valid,
//   Pkt_ack                : packet handshake to game logic
//   Busy                   : request in flight (not IDLE/ERROR)
//   Link_error             : sticky failure flag
//   Retry_count            : timeouts in the current request (saturating)
//   Parity_err             : (RX_PARITY_CHECK_EN only) parity mismatch pulse
// All outputs are registered.
// -----------------------------------------------------------------------------
module rx_link_controller
  import rx_link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = LINK_DATA_WIDTH,
  parameter int unsigned RST_CYCLES     = 20,
  parameter int unsigned BACKOFF_CYCLES = 4 * LINK_BIT_TIME,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Abort,
  output logic                  Rec_Reset,
  output logic                  Rec_en,
  input  logic [DATA_WIDTH-1:0] Rec_Dout,
  input  logic                  Rec_Timeout,
  input  logic                  Rec_OutValid,
  output logic [DATA_WIDTH-1:0] Pkt_data,
  output logic                  Pkt_valid,
  input  logic                  Pkt_ack,
  output logic                  Busy,
  output logic                  Link_error,
  output logic [1:0]            Retry_count
`ifdef RX_PARITY_CHECK_EN
  ,
  output logic                  Parity_err
`endif
);

  // Timer loads N-1 so that done rises on the N-th cycle in the state.
  localparam logic [TIMER_WIDTH-1:0] RST_LOAD_C     = TIMER_WIDTH'(RST_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] BACKOFF_LOAD_C = TIMER_WIDTH'(BACKOFF_CYCLES - 1);
  localparam logic [1:0]             MAX_RETRY_C    = 2'(MAX_RETRIES);
  localparam logic [DATA_WIDTH-1:0]  DATA_ZERO_C    = {DATA_WIDTH{1'b0}};

  link_state_e state_q;
  link_state_e state_d;

  logic                   timer_load_s;
  logic [TIMER_WIDTH-1:0] timer_val_s;
  logic                   timer_done_s;
  logic                   pkt_bad_s;

  logic [1:0]            retry_q;
  logic [1:0]            retry_d;
  logic [DATA_WIDTH-1:0] pkt_data_q;
  logic [DATA_WIDTH-1:0] pkt_data_d;
  logic                  rec_reset_q;
  logic                  rec_reset_d;
  logic                  rec_en_q;
  logic                  rec_en_d;
  logic                  pkt_valid_q;
  logic                  pkt_valid_d;
  logic                  busy_q;
  logic                  busy_d;
  logic                  link_error_q;
  logic                  link_error_d;

`ifdef RX_PARITY_CHECK_EN
  logic parity_err_q;
  logic parity_err_d;

  // MSB is even parity over the rest, so a good packet XORs to zero overall.
  function automatic logic parity_mismatch(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  assign pkt_bad_s    = Rec_OutValid && parity_mismatch(Rec_Dout);
  assign parity_err_d = (state_q == LISTEN) && !Abort && pkt_bad_s;
`else
  assign pkt_bad_s = 1'b0;
`endif

  rx_link_timer #(
    .WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .load_i     (timer_load_s),
    .load_val_i (timer_val_s),
    .done_o     (timer_done_s)
  );

  // Next-state, retry counter and packet capture.
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    pkt_data_d = pkt_data_q;
    case (state_q)
      IDLE: begin
        retry_d = 2'd0;
        if (Start) begin
          state_d = RESET_RX;
        end else begin
          state_d = IDLE;
        end
      end
      RESET_RX: begin
        if (Abort) begin
          state_d = IDLE;
          retry_d = 2'd0;
        end else if (timer_done_s) begin
          state_d = LISTEN;
        end else begin
          state_d = RESET_RX;
        end
      end
      LISTEN: begin
        if (Abort) begin
          state_d = IDLE;
          retry_d = 2'd0;
        end else if (Rec_OutValid && !pkt_bad_s) begin
          // A good packet wins over a simultaneous timeout.
          state_d    = HOLD;
          pkt_data_d = Rec_Dout;
        end else if (Rec_Timeout || pkt_bad_s) begin
          if (retry_q < MAX_RETRY_C) begin
            state_d = BACKOFF;
            retry_d = retry_q + 2'd1;
          end else begin
            state_d = ERROR;
          end
        end else begin
          state_d = LISTEN;
        end
      end
      BACKOFF: begin
        if (Abort) begin
          state_d = IDLE;
          retry_d = 2'd0;
        end else if (timer_done_s) begin
          state_d = RESET_RX;
        end else begin
          state_d = BACKOFF;
        end
      end
      HOLD: begin
        if (Pkt_ack) begin
          state_d = IDLE;
          retry_d = 2'd0;
        end else begin
          state_d = HOLD;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = IDLE;
        retry_d = 2'd0;
      end
    endcase
  end

  // Reload the timer on every entry into a timed state.
  always_comb begin
    timer_load_s = 1'b0;
    timer_val_s  = RST_LOAD_C;
    if ((state_d != state_q) && (state_d == RESET_RX)) begin
      timer_load_s = 1'b1;
      timer_val_s  = RST_LOAD_C;
    end else if ((state_d != state_q) && (state_d == BACKOFF)) begin
      timer_load_s = 1'b1;
      timer_val_s  = BACKOFF_LOAD_C;
    end else begin
      timer_load_s = 1'b0;
      timer_val_s  = RST_LOAD_C;
    end
  end

  // Outputs are decoded from the next state so the registers track state_q.
  always_comb begin
    rec_reset_d  = 1'b1;
    rec_en_d     = 1'b0;
    pkt_valid_d  = 1'b0;
    link_error_d = 1'b0;
    busy_d       = state_is_busy(state_d);
    case (state_d)
      LISTEN: begin
        rec_reset_d = 1'b0;
        rec_en_d    = 1'b1;
      end
      HOLD: begin
        // Receiver out of reset but disabled keeps its Dout frozen.
        rec_reset_d = 1'b0;
        pkt_valid_d = 1'b1;
      end
      ERROR: begin
        link_error_d = 1'b1;
      end
      default: begin
        rec_reset_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      retry_q      <= 2'd0;
      pkt_data_q   <= DATA_ZERO_C;
      rec_reset_q  <= 1'b1;
      rec_en_q     <= 1'b0;
      pkt_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      link_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      pkt_data_q   <= pkt_data_d;
      rec_reset_q  <= rec_reset_d;
      rec_en_q     <= rec_en_d;
      pkt_valid_q  <= pkt_valid_d;
      busy_q       <= busy_d;
      link_error_q <= link_error_d;
    end
  end

`ifdef RX_PARITY_CHECK_EN
  // Parity error pulse register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign Parity_err = parity_err_q;
`endif

  assign Rec_Reset   = rec_reset_q;
  assign Rec_en      = rec_en_q;
  assign Pkt_data    = pkt_data_q;
  assign Pkt_valid   = pkt_valid_q;
  assign Busy        = busy_q;
  assign Link_error  = link_error_q;
  assign Retry_count = retry_q;

endmodule

// File: doc/rx_link_controller.md
Name: rx_link_controller

Overview:
- Sequencer for the serial Receiver (Din -> 30-bit Dout, OutValid, Timeout) in the battleship link path.
- Holds the Receiver in reset when idle, arms it on request, captures a completed packet and hands it to game logic over a valid/ack handshake.
- Retries after Receiver timeouts with a backoff, and raises a sticky link error after too many failures.

Parameters:
- DATA_WIDTH, 30, packet width; must match the Receiver Dout width.
- RST_CYCLES, 20, minimum Rec_Reset pulse length before each listen attempt.
- BACKOFF_CYCLES, 108, idle gap after a timeout (one start+data+stop symbol at 27-cycle bit time).
- MAX_RETRIES, 3, timeouts tolerated before error; the attempt after MAX_RETRIES retries is the last.

Ports:
- Clock  in  1  system clock (27 MHz).
- Reset  in  1  synchronous, active-high controller reset.
- Start  in  1  request one packet; sampled in IDLE only.
- Abort  in  1  cancel current attempt; sampled in RESET_RX, LISTEN, BACKOFF.
- Rec_Reset  out  1  reset to Receiver.
- Rec_en  out  1  enable to Receiver.
- Rec_Dout  in  DATA_WIDTH  Receiver data.
- Rec_Timeout  in  1  Receiver timeout strobe.
- Rec_OutValid  in  1  Receiver packet-complete strobe.
- Pkt_data  out  DATA_WIDTH  captured packet, registered.
- Pkt_valid  out  1  Pkt_data valid.
- Pkt_ack  in  1  consumer accepts packet.
- Busy  out  1  high in every state except IDLE and ERROR.
- Link_error  out  1  sticky failure flag.
- Retry_count  out  2  timeouts in the current request, saturating at MAX_RETRIES.

Behaviour:
- Reset (synchronous, active-high) values, effective the cycle after Reset is sampled high:
  - state = IDLE.
  - Rec_Reset = 1.
  - Rec_en, Pkt_valid, Busy, Link_error, Retry_count = 0.
  - Pkt_data = 0.
- All outputs are registered.
- Rec_Reset = 1 in every state except LISTEN and HOLD.
- Rec_en = 1 only in LISTEN.
- IDLE:
  - Start -> RESET_RX.
  - Retry_count cleared to 0.
- RESET_RX:
  - Counter runs RST_CYCLES cycles, then -> LISTEN.
  - Abort -> IDLE.
- LISTEN, priority order:
  - Abort -> IDLE.
  - Rec_OutValid -> HOLD, with Pkt_data <= Rec_Dout and Pkt_valid = 1 on the next cycle (latency 1).
  - Rec_Timeout -> BACKOFF if Retry_count < MAX_RETRIES; Retry_count increments.
  - Rec_Timeout -> ERROR if Retry_count = MAX_RETRIES.
  - Rec_OutValid and Rec_Timeout in the same cycle: OutValid wins.
- BACKOFF:
  - Counter runs BACKOFF_CYCLES cycles, then -> RESET_RX.
  - Abort -> IDLE.
- HOLD:
  - Pkt_valid = 1 and Pkt_data stable until Pkt_ack; Pkt_ack -> IDLE with Pkt_valid = 0 next cycle.
  - Start and Abort are ignored.
  - Rec_en = 0, Rec_Reset = 0, so the Receiver keeps Dout frozen.
- ERROR:
  - Link_error = 1 and Rec_Reset = 1.
  - Start is ignored; only Reset exits.
- Counters reload on every state entry, so no stale counts carry over.
- Reset in any state, including mid-LISTEN or mid-HOLD, overrides all inputs.

Optional Feature:
- Macro: RX_PARITY_CHECK_EN.
- Defined:
  - On Rec_OutValid, Rec_Dout[DATA_WIDTH-1] is checked as even parity over the remaining bits.
  - A mismatch is treated exactly like Rec_Timeout (retry/ERROR path, Retry_count increments).
  - Output Parity_err (1-bit, registered) pulses for one cycle on each mismatch.
- Undefined:
  - No check; every OutValid packet is delivered.
  - Parity_err port is absent.

Decomposition:
- Shared package rx_link_pkg:
  - State encoding constants: IDLE, RESET_RX, LISTEN, BACKOFF, HOLD, ERROR.
  - DATA_WIDTH and bit-time (27) constants shared with the Receiver and the transmitter.
- One natural sub-module: rx_link_timer, a loadable down-counter with a done flag, used for both RST_CYCLES and BACKOFF_CYCLES.

Test Plan:
- Start; Rec_OutValid at cycle 40 with Rec_Dout = 30'h2AAAAAAA -> Rec_Reset held 20 cycles; then Pkt_data = 30'h2AAAAAAA and Pkt_valid = 1 one cycle after OutValid; Rec_en = 0.
- Start; Rec_Timeout on four successive listens (MAX_RETRIES = 3) -> three 108-cycle backoffs, Retry_count 1, 2, 3; then ERROR with Link_error = 1 and Busy = 0; Start ignored until Reset.
- Packet captured, Pkt_ack withheld 500 cycles, Start pulsed -> Pkt_valid and Pkt_data unchanged; Pkt_ack -> IDLE next cycle.
- Abort during LISTEN, and separately during BACKOFF -> IDLE next cycle, Rec_Reset = 1, no Pkt_valid.
- Rec_OutValid and Rec_Timeout asserted together -> packet delivered, Retry_count unchanged; Reset during HOLD -> all outputs at reset values next cycle.
- With RX_PARITY_CHECK_EN, packet 30'h00000001 (bad parity) -> Parity_err pulse, Retry_count = 1, BACKOFF; without the macro, the same packet is delivered.
